nx4_panel_monitor: RTL

- Receive-side model of the NX4 panel's LED-driver chain.
- Watches the serial driver bus (sclk, 6+6 sin lanes, mode, xlat, blank, gsclk) emitted by the panel driver.
- Deserialises each lane into a CRC, counts shifted bits per latch and gsclk pulses per blank period, and raises an active-low xerr.
- Sits on the FPGA beside the driver for loopback self-check; also serves as the bench scoreboard for driver regressions.

---
 rtl/nx4_pkg.sv | 15 +
 rtl/nx4_lane_crc.sv | 23 ++
 rtl/nx4_panel_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/nx4_pkg.sv
// nx4_pkg: shared constants, shift FSM state and CRC step for the NX4 panel monitor
package nx4_pkg;
    localparam int LANES = 12;
    localparam int LANE_L1 = 0;
    localparam int LANE_R1 = 6;
    localparam int LANE_R6 = 11;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} shift_state_t;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/nx4_lane_crc.sv
// nx4_lane_crc: MSB-first CRC-16-CCITT accumulator for one serial lane
module nx4_lane_crc
    import nx4_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        shift_en,
    input  logic        restart,
    output logic [15:0] crc
);

    // restart wins over a simultaneous bit: that bit belongs to the closing frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            crc <= CRC_INIT;
        else if (restart)
            crc <= CRC_INIT;
        else if (shift_en)
            crc <= crc_step(crc, bit_in);
    end

endmodule

// File: rtl/nx4_panel_monitor.sv
// nx4_panel_monitor: receive-side checker for the NX4 LED-driver serial bus
module nx4_panel_monitor
    import nx4_pkg::*;
#(
    parameter int INDEX_MAX       = 576,
    parameter int GSCLK_PER_BLANK = 4096,
    parameter int CNT_WIDTH       = 13
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 led_sclk,
    input  logic [5:0]           led_l_sin,
    input  logic [5:0]           led_r_sin,
    input  logic                 led_mode,
    input  logic                 led_xlat,
    input  logic                 led_blank,
    input  logic                 led_gsclk,
    input  logic [3:0]           crc_sel,
    output logic [15:0]          crc_out,
    output logic                 frame_valid,
    output logic                 frame_mode,
    output logic [CNT_WIDTH-1:0] frame_bits,
    output logic [CNT_WIDTH-1:0] gs_count,
    output logic                 err_bits,
    output logic                 err_gs,
    output logic                 led_xerr,
    input  logic                 err_clear
);

    logic sclk_q, sclk_qq, xlat_q, xlat_qq, blank_q, blank_qq, gsclk_q, gsclk_qq, mode_q;
    logic [5:0] sin_l_q, sin_r_q;
    logic [LANES-1:0] sin_all;
    logic s_rise, x_rise, b_rise, g_rise;
    logic [15:0] lane_crc [LANES];
    logic [15:0] crc_cur [LANES];
    logic [15:0] crc_lat [LANES];
    shift_state_t state, state_nxt;
    logic [CNT_WIDTH-1:0] bit_cnt, bit_nxt, gs_cnt, g_total;

    // register every pin once, then once more for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {sclk_q, sclk_qq, xlat_q, xlat_qq} <= '0;
            {blank_q, blank_qq, gsclk_q, gsclk_qq, mode_q} <= '0;
            sin_l_q <= '0;
            sin_r_q <= '0;
        end else begin
            {sclk_qq, xlat_qq, blank_qq, gsclk_qq} <= {sclk_q, xlat_q, blank_q, gsclk_q};
            {sclk_q, xlat_q, blank_q, gsclk_q} <= {led_sclk, led_xlat, led_blank, led_gsclk};
            mode_q <= led_mode;
            sin_l_q <= led_l_sin;
            sin_r_q <= led_r_sin;
        end
    end

    assign s_rise = sclk_q & ~sclk_qq;
    assign x_rise = xlat_q & ~xlat_qq;
    assign b_rise = blank_q & ~blank_qq;
    assign g_rise = gsclk_q & ~gsclk_qq;
    assign sin_all[LANE_R1-1:LANE_L1] = sin_l_q;
    assign sin_all[LANE_R6:LANE_R1] = sin_r_q;

    // crc_cur folds in a same-cycle bit so a simultaneous latch captures it
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nx4_lane_crc u_crc (
            .clock    (clock),
            .reset_n  (reset_n),
            .bit_in   (sin_all[i]),
            .shift_en (s_rise),
            .restart  (x_rise),
            .crc      (lane_crc[i])
        );
        assign crc_cur[i] = s_rise ? crc_step(lane_crc[i], sin_all[i]) : lane_crc[i];
    end

    // shift FSM next state: bit count after this cycle's sclk edge, saturating past INDEX_MAX
    always_comb begin
        state_nxt = state;
        bit_nxt = bit_cnt;
        if (s_rise) begin
            if (state == IDLE) begin
                state_nxt = SHIFT;
                bit_nxt = CNT_WIDTH'(1);
            end else if (state == SHIFT && bit_cnt == CNT_WIDTH'(INDEX_MAX)) begin
                state_nxt = OVERRUN;
                bit_nxt = CNT_WIDTH'(INDEX_MAX + 1);
            end else if (state == SHIFT) begin
                bit_nxt = bit_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // shift FSM register; a latch always returns to an empty IDLE frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= x_rise ? IDLE : state_nxt;
            bit_cnt <= x_rise ? '0 : bit_nxt;
        end
    end

    // latch snapshot of CRCs, bit count and mode, with a one-cycle valid pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) crc_lat[k] <= CRC_INIT;
            frame_valid <= 1'b0;
            frame_mode <= 1'b0;
            frame_bits <= '0;
        end else begin
            frame_valid <= x_rise;
            if (x_rise) begin
                crc_lat <= crc_cur;
                frame_bits <= bit_nxt;
                frame_mode <= mode_q;
            end
        end
    end

    assign g_total = (g_rise && !(&gs_cnt)) ? gs_cnt + CNT_WIDTH'(1) : gs_cnt;

    // gsclk counter closed by each blank rising edge, including a same-cycle gsclk edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gs_cnt <= '0;
            gs_count <= '0;
        end else begin
            gs_cnt <= b_rise ? '0 : g_total;
            if (b_rise) gs_count <= g_total;
        end
    end

    // sticky errors; a new error beats a coincident clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_bits <= 1'b0;
            err_gs <= 1'b0;
            led_xerr <= 1'b1;
        end else begin
            err_bits <= (x_rise && bit_nxt != CNT_WIDTH'(INDEX_MAX)) | (err_bits & ~err_clear);
            err_gs <= (b_rise && g_total != CNT_WIDTH'(GSCLK_PER_BLANK)) | (err_gs & ~err_clear);
            led_xerr <= ~(err_bits | err_gs);
        end
    end

    assign crc_out = (crc_sel <= 4'(LANE_R6)) ? crc_lat[crc_sel] : 16'h0000;

endmodule
